// File: rtl/vreg_read_stage.sv
// VRF read stage: turns address-generator beats into fixed-latency VRF reads and
// queues the returned data with first/last tags for the execute lane.
module vreg_read_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int OFF_WIDTH  = 8,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [OFF_WIDTH-1:0]  in_off,
    input  logic                  in_start,
    input  logic                  in_end,
    output logic                  vrf_rd_en,
    output logic [ADDR_WIDTH-1:0] vrf_rd_addr,
    output logic [OFF_WIDTH-1:0]  vrf_rd_off,
    input  logic [DATA_WIDTH-1:0] vrf_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_first,
    output logic                  out_last,
    output logic                  hold,
    output logic                  ovf,
    output logic                  op_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(FIFO_DEPTH);
    localparam logic [SUM_W-1:0] HOLD_S  = SUM_W'(FIFO_DEPTH - RD_LAT - 1);

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] inflight;
    logic [SUM_W-1:0] occ;
    logic             admit;
    logic             push;
    logic             pop;
    logic [1:0]       push_tag;

    // Occupancy counts reads already issued, so a push can never find the FIFO full.
    assign occ   = SUM_W'(fifo_count) + SUM_W'(inflight);
    assign admit = in_valid && (occ < DEPTH_S);
    assign hold  = (occ >= HOLD_S);

    // Stage p0: registered VRF read request
    logic                  rd_vld_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [OFF_WIDTH-1:0]  off_p0;
    logic [1:0]            tag_p0;

    always_ff @(posedge clk) begin
        if (!rst_n) rd_vld_p0 <= 1'b0;
        else        rd_vld_p0 <= admit;
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            addr_p0 <= in_addr;
            off_p0  <= in_off;
            tag_p0  <= {in_start, in_end};
        end
    end

    assign vrf_rd_en   = rd_vld_p0;
    assign vrf_rd_addr = addr_p0;
    assign vrf_rd_off  = off_p0;

    // Stage p1: RD_LAT-deep sideband shift, last slot aligned with vrf_rd_data
    logic       vld_p1 [RD_LAT];
    logic [1:0] tag_p1 [RD_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) vld_p1[i] <= 1'b0;
        end else begin
            vld_p1[0] <= rd_vld_p0;
            for (int i = 1; i < RD_LAT; i++) vld_p1[i] <= vld_p1[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_p1[0] <= tag_p0;
        for (int i = 1; i < RD_LAT; i++) tag_p1[i] <= tag_p1[i-1];
    end

    assign push     = vld_p1[RD_LAT-1];
    assign push_tag = tag_p1[RD_LAT-1];

    // Stage p2: output FIFO, entry = {first, last, data}
    logic [DATA_WIDTH+1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign {out_first, out_last, out_data} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {push_tag, vrf_rd_data};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            inflight   <= '0;
            ovf        <= 1'b0;
            op_done    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase

            case ({admit, push})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase

            ovf     <= ovf | (in_valid & ~admit);
            op_done <= pop & out_last;
        end
    end

endmodule

// File: tb/tb_vreg_read_stage.sv
// Directed bench for vreg_read_stage with a fixed-latency VRF model (RD_LAT=2, depth 8).
module tb_vreg_read_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [4:0]  in_addr;
    logic [7:0]  in_off;
    logic        in_start;
    logic        in_end;
    logic        vrf_rd_en;
    logic [4:0]  vrf_rd_addr;
    logic [7:0]  vrf_rd_off;
    logic [63:0] vrf_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_first;
    logic        out_last;
    logic        hold;
    logic        ovf;
    logic        op_done;

    int nchk  = 0;
    int nfail = 0;

    vreg_read_stage #(
        .DATA_WIDTH(64), .ADDR_WIDTH(5), .OFF_WIDTH(8), .RD_LAT(2), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_addr(in_addr), .in_off(in_off),
        .in_start(in_start), .in_end(in_end),
        .vrf_rd_en(vrf_rd_en), .vrf_rd_addr(vrf_rd_addr), .vrf_rd_off(vrf_rd_off),
        .vrf_rd_data(vrf_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_first(out_first), .out_last(out_last),
        .hold(hold), .ovf(ovf), .op_done(op_done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] vdat(input logic [4:0] a, input logic [7:0] o);
        return {8'hA0, 3'b000, a, 40'h0, o};
    endfunction

    // VRF model: data for the request seen in a cycle appears two cycles later
    logic [63:0] rdpipe0, rdpipe1;
    always @(posedge clk) begin
        rdpipe0 <= vdat(vrf_rd_addr, vrf_rd_off);
        rdpipe1 <= rdpipe0;
    end
    assign vrf_rd_data = rdpipe1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [7:0] o,
                         input logic s, input logic e);
        in_valid = v;
        in_addr  = a;
        in_off   = o;
        in_start = s;
        in_end   = e;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [63:0] t6_data [5];
    logic [1:0]  t6_tag  [5];
    int          pops;
    int          dones;

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_rd_en",     64'(vrf_rd_en), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_ovf",       64'(ovf),       64'd0);
        chk("rst_op_done",   64'(op_done),   64'd0);
        chk("rst_hold",      64'(hold),      64'd0);
        rst_n = 1'b1;
        step();

        // 1: four-beat op, consumer always ready
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 4) drive(1'b1, 5'd3, 8'(c), c == 0, c == 3);
            else       drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
            step();
            chk("t1_rd_en", 64'(vrf_rd_en), 64'(c < 4));
            if (c < 4) begin
                chk("t1_rd_addr", 64'(vrf_rd_addr), 64'd3);
                chk("t1_rd_off",  64'(vrf_rd_off),  64'(c));
            end
            chk("t1_out_valid", 64'(out_valid), 64'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) begin
                chk("t1_data",  out_data,        vdat(5'd3, 8'(c - 3)));
                chk("t1_first", 64'(out_first),  64'(c == 3));
                chk("t1_last",  64'(out_last),   64'(c == 6));
            end
            chk("t1_op_done", 64'(op_done), 64'(c == 7));
            chk("t1_hold",    64'(hold),    64'd0);
        end

        // 2: consumer stalled, fill to eight then overflow on the ninth
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (k < 8) drive(1'b1, 5'd5, 8'(k), k == 0, k == 7);
            else       drive(1'b1, 5'd6, 8'd8, 1'b1, 1'b1);
            step();
            chk("t2_hold",  64'(hold),      64'(k >= 4));
            chk("t2_rd_en", 64'(vrf_rd_en), 64'(k < 8));
            chk("t2_ovf",   64'(ovf),       64'(k == 8));
        end
        drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
        step();
        step();
        step();
        chk("t2_full_valid", 64'(out_valid), 64'd1);
        chk("t2_full_hold",  64'(hold),      64'd1);
        chk("t2_head_data",  out_data,       vdat(5'd5, 8'd0));
        chk("t2_head_first", 64'(out_first), 64'd1);

        // 3: drain from full while new beats stream in
        out_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            if (k <= 6) drive(1'b1, 5'd7, 8'(8'h10 + k), k == 0, k == 6);
            else        drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
            step();
            if (k == 0) chk("t3_rd_en_drop", 64'(vrf_rd_en), 64'd0);
            if (k == 1) chk("t3_rd_en_adm",  64'(vrf_rd_en), 64'd1);
            chk("t3_out_valid", 64'(out_valid), 64'(k < 13));
            if (k < 13) begin
                if (k + 1 < 8) begin
                    chk("t3_data", out_data,       vdat(5'd5, 8'(k + 1)));
                    chk("t3_last", 64'(out_last),  64'(k + 1 == 7));
                end else begin
                    chk("t3_data", out_data,       vdat(5'd7, 8'(8'h10 + k - 6)));
                    chk("t3_last", 64'(out_last),  64'(k - 6 == 6));
                end
                chk("t3_first", 64'(out_first), 64'd0);
            end
            chk("t3_op_done", 64'(op_done), 64'(k == 7 || k == 13));
            chk("t3_ovf",     64'(ovf),     64'd1);
        end

        // 4: single-beat op
        for (int k = 0; k < 5; k++) begin
            if (k == 0) drive(1'b1, 5'd9, 8'd0, 1'b1, 1'b1);
            else        drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
            step();
            chk("t4_out_valid", 64'(out_valid), 64'(k == 3));
            if (k == 3) begin
                chk("t4_data",  out_data,       vdat(5'd9, 8'd0));
                chk("t4_first", 64'(out_first), 64'd1);
                chk("t4_last",  64'(out_last),  64'd1);
            end
            chk("t4_op_done", 64'(op_done), 64'(k == 4));
        end

        // 5: reset with three queued and two in flight
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k < 5) drive(1'b1, 5'd10, 8'(k), k == 0, 1'b0);
            else       drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
            step();
        end
        chk("t5_pre_hold",  64'(hold),      64'd1);
        chk("t5_pre_valid", 64'(out_valid), 64'd1);
        chk("t5_pre_ovf",   64'(ovf),       64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_ovf",   64'(ovf),       64'd0);
        chk("t5_rst_hold",  64'(hold),      64'd0);
        chk("t5_rst_rd_en", 64'(vrf_rd_en), 64'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_no_push", 64'(out_valid), 64'd0);
        end

        // 6: back-to-back ops with the consumer toggling ready
        t6_data[0] = vdat(5'd12, 8'd0); t6_tag[0] = 2'b10;
        t6_data[1] = vdat(5'd12, 8'd1); t6_tag[1] = 2'b00;
        t6_data[2] = vdat(5'd12, 8'd2); t6_tag[2] = 2'b01;
        t6_data[3] = vdat(5'd13, 8'd0); t6_tag[3] = 2'b10;
        t6_data[4] = vdat(5'd13, 8'd1); t6_tag[4] = 2'b01;
        pops  = 0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            case (c)
                0:       drive(1'b1, 5'd12, 8'd0, 1'b1, 1'b0);
                1:       drive(1'b1, 5'd12, 8'd1, 1'b0, 1'b0);
                2:       drive(1'b1, 5'd12, 8'd2, 1'b0, 1'b1);
                3:       drive(1'b1, 5'd13, 8'd0, 1'b1, 1'b0);
                4:       drive(1'b1, 5'd13, 8'd1, 1'b0, 1'b1);
                default: drive(1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
            endcase
            step();
            if (op_done) dones++;
            out_ready = (c % 2) == 1;
            if (out_valid && out_ready) begin
                if (pops < 5) begin
                    chk("t6_data", out_data, t6_data[pops]);
                    chk("t6_tag",  64'({out_first, out_last}), 64'(t6_tag[pops]));
                end
                pops++;
            end
        end
        chk("t6_pops",    64'(pops),  64'd5);
        chk("t6_op_done", 64'(dones), 64'd2);
        chk("t6_ovf",     64'(ovf),   64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
